// File: rtl/dcm_ps_pkg.sv
// Shared definitions for the DCM phase-shift responder: FSM encoding,
// phase/counter widths and default timing/limit parameters.
// Ports: none (package only).
package dcm_ps_pkg;

  localparam int PHASE_W           = 8;
  localparam int CNT_W             = 8;
  localparam int DEFAULT_LATENCY   = 8;
  localparam int DEFAULT_PHASE_MAX = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ps_state_e;

endpackage

// File: rtl/dcm_ps_responder_if.sv
// Phase-shift request/response bundle between a requester and the responder.
// Ports: PSEN/PSINCDEC (request strobe + direction), PSDONE (completion pulse),
//        phase (signed offset), busy, at_limit, ps_err (status flags).
interface dcm_ps_responder_if;
  import dcm_ps_pkg::*;

  logic               PSEN;
  logic               PSINCDEC;
  logic               PSDONE;
  logic [PHASE_W-1:0] phase;
  logic               busy;
  logic               at_limit;
  logic               ps_err;

  // Requester side.
  modport master (
    output PSEN, PSINCDEC,
    input  PSDONE, phase, busy, at_limit, ps_err
  );

  // Responder side.
  modport slave (
    input  PSEN, PSINCDEC,
    output PSDONE, phase, busy, at_limit, ps_err
  );

endinterface

// File: rtl/ps_delay_counter.sv
// Down-counter timing a phase-shift request: load, decrement, terminal count.
// Ports: clk, reset (sync, active-high), load/load_val, dec, count, tc
//        (tc is high while count is zero).
module ps_delay_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_q = '0;
  logic [W-1:0] count_d;

  // Load wins over decrement; decrement stops at zero rather than wrapping.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == '0);

endmodule

// File: rtl/dcm_ps_responder.sv
// Behavioural responder for a DCM dynamic phase-shift port: accepts a PSEN
// strobe, waits LATENCY cycles, then pulses PSDONE and steps a saturating
// signed phase. Ports: clk, reset (sync, active-high), ps (slave side of
// dcm_ps_responder_if: PSEN, PSINCDEC, PSDONE, phase, busy, at_limit, ps_err).
module dcm_ps_responder
  import dcm_ps_pkg::*;
#(
  parameter int LATENCY   = DEFAULT_LATENCY,
  parameter int PHASE_MAX = DEFAULT_PHASE_MAX
) (
  input  logic                 clk,
  input  logic                 reset,
  dcm_ps_responder_if.slave    ps
);

  localparam logic signed [PHASE_W-1:0] PH_POS = PHASE_W'(PHASE_MAX);
  localparam logic signed [PHASE_W-1:0] PH_NEG = -PH_POS;

  // Acceptance edge k already counts as one cycle and the DONE entry edge is
  // k+LATENCY-1, so SHIFT lasts LATENCY-1 cycles: load LATENCY-2 and leave
  // SHIFT on the cycle the counter reads zero.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

  ps_state_e                 state_q = IDLE;
  ps_state_e                 state_d;
  logic signed [PHASE_W-1:0] phase_q = '0;
  logic signed [PHASE_W-1:0] phase_d;
  logic                      dir_q   = 1'b0;
  logic                      dir_d;
  logic                      ps_err_q = 1'b0;
  logic                      ps_err_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_tc;

  ps_delay_counter #(.W(CNT_W)) u_delay (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CNT_LOAD),
    .dec      (cnt_dec),
    .count    (cnt_val),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    dir_d    = dir_q;
    ps_err_d = ps_err_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ps.PSEN) begin
          dir_d    = ps.PSINCDEC;
          cnt_load = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // A strobe while busy is dropped; only the sticky error records it.
        if (ps.PSEN) ps_err_d = 1'b1;
        if (cnt_tc) begin
          state_d = DONE;
          // Saturate at the limits instead of wrapping; PSDONE still fires.
          if (dir_q) begin
            if (phase_q < PH_POS) phase_d = phase_q + PHASE_W'(1);
          end else begin
            if (phase_q > PH_NEG) phase_d = phase_q - PHASE_W'(1);
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        if (ps.PSEN) ps_err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      dir_q    <= 1'b0;
      ps_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      dir_q    <= dir_d;
      ps_err_q <= ps_err_d;
    end
  end

  assign ps.PSDONE   = (state_q == DONE);
  assign ps.busy     = (state_q != IDLE);
  assign ps.phase    = phase_q;
  assign ps.ps_err   = ps_err_q;
  assign ps.at_limit = (phase_q == PH_POS) || (phase_q == PH_NEG);

endmodule

// File: doc/dcm_ps_responder.md
DCM_PS_RESPONDER -- requirements
Module: dcm_ps_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 8, giving the number of clk cycles from PSEN acceptance to the PSDONE pulse; legal range 2..255.
REQ-002 The block SHALL have parameter PHASE_MAX, default 15, giving the magnitude limit of the phase offset; legal range 1..127.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port PSEN, input, 1 bit: phase-shift request strobe, one cycle wide.
REQ-006 The block SHALL have port PSINCDEC, input, 1 bit: shift direction sampled with PSEN; 1 = increment, 0 = decrement.
REQ-007 The block SHALL have port PSDONE, output, 1 bit: one-cycle completion pulse.
REQ-008 The block SHALL have port phase, output, 8 bits, two's-complement signed: current phase offset.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a request is in progress.
REQ-010 The block SHALL have port at_limit, output, 1 bit: high while phase equals +PHASE_MAX or -PHASE_MAX.
REQ-011 The block SHALL have port ps_err, output, 1 bit: sticky flag set when PSEN arrives while busy.

Function
REQ-012 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 In IDLE, a sampled PSEN=1 SHALL latch PSINCDEC, load the delay counter and move the FSM to SHIFT at the same edge (call this edge k).
REQ-014 In SHIFT, the counter SHALL decrement once per cycle, and the FSM SHALL move to DONE at edge k+LATENCY-1.
REQ-015 PSDONE SHALL be high only in DONE, i.e. for exactly the one cycle following edge k+LATENCY-1.
REQ-016 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-017 phase SHALL update at the edge that enters DONE: +1 if the latched direction is 1 and phase < +PHASE_MAX; -1 if the latched direction is 0 and phase > -PHASE_MAX; otherwise unchanged (saturate, never wrap).
REQ-018 PSDONE SHALL pulse for every accepted request, including requests saturated at the limit.
REQ-019 busy SHALL be high in SHIFT and DONE and low in IDLE.
REQ-020 A PSEN sampled in SHIFT or DONE SHALL be ignored (no queueing, no effect on phase or timing) and SHALL set ps_err at that edge.
REQ-021 ps_err SHALL clear only on reset.
REQ-022 A PSEN sampled in IDLE at the edge immediately after DONE SHALL be accepted normally (back-to-back rate of one request per LATENCY+1 cycles).
REQ-023 PSINCDEC SHALL be don't-care whenever PSEN=0.
REQ-024 at_limit SHALL be a combinational decode of the registered phase.

Reset
REQ-025 While reset=1 at an edge, the block SHALL set the state to IDLE, counter=0, phase=0, PSDONE=0, busy=0 and ps_err=0; at_limit=0 follows from phase=0.
REQ-026 Reset SHALL take priority over PSEN at the same edge.
REQ-027 Reset during SHIFT SHALL abort the request with no PSDONE and no phase change.
REQ-028 All registers SHALL have power-up initial values equal to their reset values.

Structure
REQ-029 A shared package dcm_ps_pkg SHALL hold the FSM state encoding (IDLE, SHIFT, DONE), the PHASE_W=8 width constant, and the default LATENCY and PHASE_MAX values.
REQ-030 The delay counter SHALL be a sub-module ps_delay_counter (load, decrement, terminal-count output), width 8.
REQ-031 The FSM, phase register and flags SHALL live in the top module.

Verification
REQ-032 Reset test: drive reset high for 2 cycles with PSEN=1 -> PSDONE=0, phase=0, busy=0, ps_err=0, at_limit=0.
REQ-033 Single increment, LATENCY=8: PSEN=1 and PSINCDEC=1 at edge k -> busy high after k, PSDONE high only in the cycle after edge k+7, phase 0->1 at edge k+7.
REQ-034 Saturation: 16 increments -> phase=15 and at_limit=1; a 17th increment -> PSDONE pulses and phase stays 15; mirror test at -15.
REQ-035 Busy collision: a second PSEN 3 cycles after acceptance -> exactly one PSDONE, phase changes by 1, ps_err=1 and it stays 1 until reset.
REQ-036 Back-to-back: a second PSEN at the edge right after the PSDONE cycle -> accepted, second PSDONE 9 cycles after the first, phase changes by 2 total.
REQ-037 Reset mid-shift: reset at edge k+4 -> no PSDONE, phase=0, and the next PSEN is accepted normally.
